// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of free PR tags popped by dispatch,
// refilled by retire, and restored to full on rollback.
module free_list #(
    parameter int C_DP_NUM       = 2,
    parameter int C_RT_NUM       = 2,
    parameter int C_ARCH_REG_NUM = 32,
    parameter int C_PHY_REG_NUM  = 64,
    localparam int DEPTH = C_PHY_REG_NUM - C_ARCH_REG_NUM,
    localparam int TAG_W = $clog2(C_PHY_REG_NUM),
    localparam int IDX_W = $clog2(DEPTH),
    localparam int PTR_W = IDX_W + 1,
    localparam int AV_W  = $clog2(C_DP_NUM + 1),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      rollback_i,
    input  logic [C_DP_NUM-1:0]       dp_req_i,
    output logic [C_DP_NUM*TAG_W-1:0] fl_tag_o,
    output logic [AV_W-1:0]           fl_avail_o,
    input  logic [C_RT_NUM-1:0]       rt_valid_i,
    input  logic [C_RT_NUM*TAG_W-1:0] rt_tag_i,
    output logic [CNT_W-1:0]          fl_count_o
);

    logic [TAG_W-1:0] entry_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] count;
    logic [PTR_W-1:0] npop, npush;

    assign count      = tail_q - head_q;
    assign fl_count_o = CNT_W'(count);
    assign fl_avail_o = (count >= PTR_W'(C_DP_NUM)) ? AV_W'(C_DP_NUM) : AV_W'(count);

    // Zero-latency read: slot i always shows entry[head+i], valid or not.
    always_comb begin
        fl_tag_o = '0;
        for (int i = 0; i < C_DP_NUM; i++)
            fl_tag_o[i*TAG_W +: TAG_W] = entry_q[IDX_W'(head_q + PTR_W'(i))];
    end

    always_comb begin
        npop  = '0;
        npush = '0;
        for (int i = 0; i < C_DP_NUM; i++) npop  = npop  + PTR_W'(dp_req_i[i]);
        for (int j = 0; j < C_RT_NUM; j++) npush = npush + PTR_W'(rt_valid_i[j]);
    end

    // Rollback: every slot that is not a retired push becomes free again, so the
    // ring is full starting right after the last push of this cycle.
    always_comb begin
        tail_d = tail_q + npush;
        head_d = head_q + npop;
        if (rollback_i)
            head_d = {~tail_d[PTR_W-1], tail_d[PTR_W-2:0]};
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++)
                entry_q[i] <= TAG_W'(C_ARCH_REG_NUM + i);
            head_q <= '0;
            tail_q <= {1'b1, {(PTR_W-1){1'b0}}};
        end else begin
            for (int j = 0; j < C_RT_NUM; j++)
                if (rt_valid_i[j])
                    entry_q[IDX_W'(tail_q + PTR_W'(j))] <= rt_tag_i[j*TAG_W +: TAG_W];
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Protocol checks on the surrounding pipeline; the RTL does not correct these.
    a_pop_avail: assert property (@(posedge clk_i) disable iff (!rst_i)
        !rollback_i |-> ($countones(dp_req_i) <= int'(fl_avail_o)));
    a_no_ovf: assert property (@(posedge clk_i) disable iff (!rst_i)
        !rollback_i |-> (int'(count) + $countones(rt_valid_i) - $countones(dp_req_i) <= DEPTH));
    a_dp_therm: assert property (@(posedge clk_i) disable iff (!rst_i)
        ((dp_req_i + C_DP_NUM'(1)) & dp_req_i) == '0);
    a_rt_therm: assert property (@(posedge clk_i) disable iff (!rst_i)
        ((rt_valid_i + C_RT_NUM'(1)) & rt_valid_i) == '0);

    for (genvar j = 0; j < C_RT_NUM; j++) begin : g_tag0
        a_no_tag0: assert property (@(posedge clk_i) disable iff (!rst_i)
            rt_valid_i[j] |-> (rt_tag_i[j*TAG_W +: TAG_W] != '0));
    end

endmodule
